mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_pkg.sv | 59 +++++
 rtl/mc_decode.sv | 58 +++++
 rtl/mc_control.sv | 160 ++++++++++++++++
 tb/tb_mc_control.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle controller: state encodings, opcode and
// funct constants, ALU codes and the latched control word.
package mc_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_XOR  = 2'd2;
    localparam logic [1:0] ALU_SLT  = 2'd3;

    // K_NONE is zero so a cleared control word decodes as "nothing to do"
    typedef enum logic [3:0] {
        K_NONE, K_RALU, K_JR, K_J, K_JAL, K_BEQ, K_BNE, K_LW, K_SW, K_ADDI, K_XORI
    } kind_t;

    typedef struct packed {
        kind_t      kind;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    function automatic state_t ex_next(input kind_t k);
        state_t nxt;
        case (k)
            K_LW, K_SW:                    nxt = S_MEM;
            K_RALU, K_ADDI, K_XORI, K_JAL: nxt = S_WB;
            default:                       nxt = S_IF;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: opcode/funct to control word plus an
// unsupported-instruction flag.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl    = CTRL_NONE;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin ctrl.kind = K_RALU; ctrl.alu_op = ALU_ADD; end
                    FN_SUB: begin ctrl.kind = K_RALU; ctrl.alu_op = ALU_SUB; end
                    FN_SLT: begin ctrl.kind = K_RALU; ctrl.alu_op = ALU_SLT; end
                    FN_JR:  ctrl.kind = K_JR;
                    default: illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                ctrl.kind       = K_LW;
                ctrl.alu_src    = 1'b1;
                ctrl.reg_dst    = 2'd2;
                ctrl.mem_to_reg = 2'd1;
            end
            OP_SW: begin
                ctrl.kind    = K_SW;
                ctrl.alu_src = 1'b1;
            end
            OP_J:   ctrl.kind = K_J;
            OP_JAL: begin
                ctrl.kind       = K_JAL;
                ctrl.reg_dst    = 2'd1;
                ctrl.mem_to_reg = 2'd2;
            end
            OP_BEQ: begin ctrl.kind = K_BEQ; ctrl.alu_op = ALU_SUB; end
            OP_BNE: begin ctrl.kind = K_BNE; ctrl.alu_op = ALU_SUB; end
            OP_ADDI: begin
                ctrl.kind    = K_ADDI;
                ctrl.alu_src = 1'b1;
                ctrl.reg_dst = 2'd2;
            end
            OP_XORI: begin
                ctrl.kind    = K_XORI;
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = ALU_XOR;
                ctrl.reg_dst = 2'd2;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle datapath controller: state register, latched control word and
// memory wait watchdog; strobes decoded from the current state.
//
//   state | meaning
//   IF    | fetch, waits on mem_ready, writes IR and PC+4
//   ID    | decode and latch control word, operand address generation
//   EX    | ALU operation, branch/jump PC update
//   MEM   | load/store access, waits on mem_ready
//   WB    | register file write-back
//   ERR   | unsupported instruction or wait timeout, left only by reset
module mc_control
    import mc_pkg::*;
#(
    parameter int ALU_CTRL_W  = 3,
    parameter int MEM_WAIT_EN = 1,
    parameter int WAIT_MAX    = 15
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic [1:0]            reg_dst,
    output logic                  reg_wr,
    output logic                  alu_src,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [1:0]            mem_to_reg,
    output logic [1:0]            pc_src,
    output logic                  pc_wr,
    output logic                  ir_wr,
    output logic                  addr_gen,
    output logic                  ab_wr,
    output logic                  instr_done,
    output logic                  illegal,
    output logic [2:0]            state
);

    localparam int CNT_W = $clog2(WAIT_MAX + 2);

    state_t           st;
    ctrl_t            cw;
    ctrl_t            dec_ctrl;
    logic             dec_illegal;
    logic [CNT_W-1:0] wait_cnt;
    logic             illegal_q;
    logic             ready;

    mc_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    assign ready = (MEM_WAIT_EN == 0) || mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= S_IF;
            cw        <= CTRL_NONE;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (st)
                S_IF, S_MEM: begin
                    if (ready) begin
                        wait_cnt <= '0;
                        if (st == S_IF)
                            st <= S_ID;
                        else
                            st <= (cw.kind == K_LW) ? S_WB : S_IF;
                    end else if (wait_cnt == CNT_W'(WAIT_MAX)) begin
                        // this is wait cycle WAIT_MAX+1: give up instead of waiting again
                        wait_cnt  <= '0;
                        st        <= S_ERR;
                        illegal_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_ID: begin
                    cw <= dec_ctrl;
                    if (dec_illegal) begin
                        st        <= S_ERR;
                        illegal_q <= 1'b1;
                    end else begin
                        st <= S_EX;
                    end
                end
                S_EX:  st <= ex_next(cw.kind);
                S_WB:  st <= S_IF;
                S_ERR: st <= S_ERR;
                default: begin
                    st        <= S_ERR;
                    illegal_q <= 1'b1;
                end
            endcase
        end
    end

    // Reset gates every output combinationally so strobes drop in the reset cycle itself
    always_comb begin
        reg_dst    = 2'd0;
        reg_wr     = 1'b0;
        alu_src    = 1'b0;
        alu_ctrl   = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_to_reg = 2'd0;
        pc_src     = 2'd0;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        addr_gen   = 1'b0;
        ab_wr      = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        state      = 3'd0;
        if (!reset) begin
            state   = st;
            illegal = illegal_q;
            case (st)
                S_IF: begin
                    mem_rd = 1'b1;
                    ir_wr  = ready;
                    pc_wr  = ready;
                end
                S_ID: addr_gen = 1'b1;
                S_EX: begin
                    ab_wr      = 1'b1;
                    alu_src    = cw.alu_src;
                    alu_ctrl   = ALU_CTRL_W'(cw.alu_op);
                    instr_done = (ex_next(cw.kind) == S_IF);
                    case (cw.kind)
                        K_BEQ: if (zero)  begin pc_wr = 1'b1; pc_src = 2'd1; end
                        K_BNE: if (!zero) begin pc_wr = 1'b1; pc_src = 2'd1; end
                        K_J, K_JAL: begin pc_wr = 1'b1; pc_src = 2'd2; end
                        K_JR:       begin pc_wr = 1'b1; pc_src = 2'd3; end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_rd     = (cw.kind == K_LW);
                    mem_wr     = (cw.kind == K_SW);
                    instr_done = ready && (cw.kind == K_SW);
                end
                S_WB: begin
                    reg_wr     = 1'b1;
                    reg_dst    = cw.reg_dst;
                    mem_to_reg = cw.mem_to_reg;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Cycle-by-cycle vector bench for mc_control: three instances (default,
// WAIT_MAX=2, MEM_WAIT_EN=0) share stimulus; each row names the instance it checks.
module tb_mc_control;

    typedef struct packed {
        logic [1:0] reg_dst;
        logic       reg_wr;
        logic       alu_src;
        logic [2:0] alu_ctrl;
        logic       mem_rd;
        logic       mem_wr;
        logic [1:0] mem_to_reg;
        logic [1:0] pc_src;
        logic       pc_wr;
        logic       ir_wr;
        logic       addr_gen;
        logic       ab_wr;
        logic       instr_done;
        logic       illegal;
        logic [2:0] state;
    } out_t;

    typedef struct {
        int         dut;
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        out_t       exp;
        string      name;
    } vec_t;

    typedef struct {
        int    dut;
        out_t  exp;
        string name;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    out_t act [3];
    vec_t tbl [$];
    sb_t  sbq [$];
    int   errors = 0;
    int   checks = 0;

    int         cur_dut = 0;
    logic [5:0] cur_op = 6'h00;
    logic [5:0] cur_fn = 6'h00;
    logic       cur_z = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [1:0] reg_dst, mem_to_reg, pc_src;
        logic [2:0] alu_ctrl, state;
        logic reg_wr, alu_src, mem_rd, mem_wr, pc_wr, ir_wr, addr_gen, ab_wr, instr_done, illegal;

        mc_control #(
            .ALU_CTRL_W  (3),
            .MEM_WAIT_EN ((g == 2) ? 0 : 1),
            .WAIT_MAX    ((g == 1) ? 2 : 15)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .opcode     (opcode),
            .funct      (funct),
            .zero       (zero),
            .mem_ready  (mem_ready),
            .reg_dst    (reg_dst),
            .reg_wr     (reg_wr),
            .alu_src    (alu_src),
            .alu_ctrl   (alu_ctrl),
            .mem_rd     (mem_rd),
            .mem_wr     (mem_wr),
            .mem_to_reg (mem_to_reg),
            .pc_src     (pc_src),
            .pc_wr      (pc_wr),
            .ir_wr      (ir_wr),
            .addr_gen   (addr_gen),
            .ab_wr      (ab_wr),
            .instr_done (instr_done),
            .illegal    (illegal),
            .state      (state)
        );

        assign act[g] = {reg_dst, reg_wr, alu_src, alu_ctrl, mem_rd, mem_wr, mem_to_reg,
                         pc_src, pc_wr, ir_wr, addr_gen, ab_wr, instr_done, illegal, state};
    end

    function automatic out_t o_rst();
        out_t o;
        o = '0;
        return o;
    endfunction

    function automatic out_t o_if(input logic rdy);
        out_t o;
        o = '0;
        o.state  = 3'd0;
        o.mem_rd = 1'b1;
        o.ir_wr  = rdy;
        o.pc_wr  = rdy;
        return o;
    endfunction

    function automatic out_t o_id();
        out_t o;
        o = '0;
        o.state    = 3'd1;
        o.addr_gen = 1'b1;
        return o;
    endfunction

    function automatic out_t o_ex(input logic src, input logic [2:0] ctl, input logic pw,
                                  input logic [1:0] ps, input logic done);
        out_t o;
        o = '0;
        o.state      = 3'd2;
        o.ab_wr      = 1'b1;
        o.alu_src    = src;
        o.alu_ctrl   = ctl;
        o.pc_wr      = pw;
        o.pc_src     = ps;
        o.instr_done = done;
        return o;
    endfunction

    function automatic out_t o_mem(input logic rd, input logic wr, input logic done);
        out_t o;
        o = '0;
        o.state      = 3'd3;
        o.mem_rd     = rd;
        o.mem_wr     = wr;
        o.instr_done = done;
        return o;
    endfunction

    function automatic out_t o_wb(input logic [1:0] dst, input logic [1:0] m2r);
        out_t o;
        o = '0;
        o.state      = 3'd4;
        o.reg_wr     = 1'b1;
        o.reg_dst    = dst;
        o.mem_to_reg = m2r;
        o.instr_done = 1'b1;
        return o;
    endfunction

    function automatic out_t o_err();
        out_t o;
        o = '0;
        o.state   = 3'd5;
        o.illegal = 1'b1;
        return o;
    endfunction

    task automatic add(input logic r, input logic rdy, input out_t e, input string nm);
        vec_t v;
        v.dut  = cur_dut;
        v.rst  = r;
        v.op   = cur_op;
        v.fn   = cur_fn;
        v.z    = cur_z;
        v.rdy  = rdy;
        v.exp  = e;
        v.name = nm;
        tbl.push_back(v);
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        cur_op = op;
        cur_fn = fn;
        cur_z  = z;
    endtask

    task automatic build_table();
        cur_dut = 0;
        instr(6'h00, 6'h20, 1'b0);
        add(1, 1, o_rst(), "reset0");
        add(1, 0, o_rst(), "reset1");
        // ADD with one fetch wait
        add(0, 0, o_if(0), "add_if_wait");
        add(0, 1, o_if(1), "add_if");
        add(0, 1, o_id(), "add_id");
        add(0, 1, o_ex(0, 3'd0, 0, 2'd0, 0), "add_ex");
        add(0, 1, o_wb(2'd0, 2'd0), "add_wb");
        instr(6'h00, 6'h22, 1'b0);
        add(0, 1, o_if(1), "sub_if"); add(0, 1, o_id(), "sub_id");
        add(0, 1, o_ex(0, 3'd1, 0, 2'd0, 0), "sub_ex"); add(0, 1, o_wb(2'd0, 2'd0), "sub_wb");
        instr(6'h00, 6'h2a, 1'b0);
        add(0, 1, o_if(1), "slt_if"); add(0, 1, o_id(), "slt_id");
        add(0, 1, o_ex(0, 3'd3, 0, 2'd0, 0), "slt_ex"); add(0, 1, o_wb(2'd0, 2'd0), "slt_wb");
        instr(6'h08, 6'h15, 1'b0);
        add(0, 1, o_if(1), "addi_if"); add(0, 1, o_id(), "addi_id");
        add(0, 1, o_ex(1, 3'd0, 0, 2'd0, 0), "addi_ex"); add(0, 1, o_wb(2'd2, 2'd0), "addi_wb");
        instr(6'h0e, 6'h00, 1'b0);
        add(0, 1, o_if(1), "xori_if"); add(0, 1, o_id(), "xori_id");
        add(0, 1, o_ex(1, 3'd2, 0, 2'd0, 0), "xori_ex"); add(0, 1, o_wb(2'd2, 2'd0), "xori_wb");
        instr(6'h03, 6'h00, 1'b0);
        add(0, 1, o_if(1), "jal_if"); add(0, 1, o_id(), "jal_id");
        add(0, 1, o_ex(0, 3'd0, 1, 2'd2, 0), "jal_ex"); add(0, 1, o_wb(2'd1, 2'd2), "jal_wb");
        instr(6'h02, 6'h00, 1'b0);
        add(0, 1, o_if(1), "j_if"); add(0, 1, o_id(), "j_id");
        add(0, 1, o_ex(0, 3'd0, 1, 2'd2, 1), "j_ex");
        instr(6'h00, 6'h08, 1'b0);
        add(0, 1, o_if(1), "jr_if"); add(0, 1, o_id(), "jr_id");
        add(0, 1, o_ex(0, 3'd0, 1, 2'd3, 1), "jr_ex");
        instr(6'h04, 6'h00, 1'b1);
        add(0, 1, o_if(1), "beq_t_if"); add(0, 1, o_id(), "beq_t_id");
        add(0, 1, o_ex(0, 3'd1, 1, 2'd1, 1), "beq_t_ex");
        instr(6'h04, 6'h00, 1'b0);
        add(0, 1, o_if(1), "beq_n_if"); add(0, 1, o_id(), "beq_n_id");
        add(0, 1, o_ex(0, 3'd1, 0, 2'd0, 1), "beq_n_ex");
        instr(6'h05, 6'h00, 1'b0);
        add(0, 1, o_if(1), "bne_t_if"); add(0, 1, o_id(), "bne_t_id");
        add(0, 1, o_ex(0, 3'd1, 1, 2'd1, 1), "bne_t_ex");
        instr(6'h05, 6'h00, 1'b1);
        add(0, 1, o_if(1), "bne_n_if"); add(0, 1, o_id(), "bne_n_id");
        add(0, 1, o_ex(0, 3'd1, 0, 2'd0, 1), "bne_n_ex");
        instr(6'h2b, 6'h00, 1'b0);
        add(0, 1, o_if(1), "sw_if"); add(0, 1, o_id(), "sw_id");
        add(0, 1, o_ex(1, 3'd0, 0, 2'd0, 0), "sw_ex");
        add(0, 0, o_mem(0, 1, 0), "sw_mem_wait"); add(0, 1, o_mem(0, 1, 1), "sw_mem");
        // LW with three memory waits: eight cycles in total
        instr(6'h23, 6'h00, 1'b0);
        add(0, 1, o_if(1), "lw_if"); add(0, 1, o_id(), "lw_id");
        add(0, 1, o_ex(1, 3'd0, 0, 2'd0, 0), "lw_ex");
        for (int i = 0; i < 3; i++) add(0, 0, o_mem(1, 0, 0), "lw_mem_wait");
        add(0, 1, o_mem(1, 0, 0), "lw_mem"); add(0, 1, o_wb(2'd2, 2'd1), "lw_wb");
        // reset during the MEM cycle of SW
        instr(6'h2b, 6'h00, 1'b0);
        add(0, 1, o_if(1), "swr_if"); add(0, 1, o_id(), "swr_id");
        add(0, 1, o_ex(1, 3'd0, 0, 2'd0, 0), "swr_ex");
        add(1, 1, o_rst(), "swr_mem_reset"); add(0, 0, o_if(0), "swr_after_reset");
        add(1, 1, o_rst(), "reset2");
        // unsupported opcode, ERR sticky for 10 cycles
        instr(6'h3f, 6'h00, 1'b0);
        add(0, 1, o_if(1), "ill_if"); add(0, 1, o_id(), "ill_id");
        for (int i = 0; i < 10; i++) add(0, (i % 2 == 0), o_err(), "ill_err");
        add(1, 1, o_rst(), "ill_reset"); add(0, 1, o_if(1), "ill_after_reset");
        instr(6'h00, 6'h21, 1'b0);
        add(0, 1, o_id(), "badfn_id"); add(0, 1, o_err(), "badfn_err");
        add(1, 1, o_rst(), "reset3");
        // default WAIT_MAX=15: 16 waiting fetch cycles then ERR
        instr(6'h00, 6'h20, 1'b0);
        for (int i = 0; i < 16; i++) add(0, 0, o_if(0), "if_wait15");
        add(0, 0, o_err(), "if_timeout15");
        add(1, 1, o_rst(), "reset4");

        cur_dut = 1;
        add(1, 1, o_rst(), "w2_reset");
        for (int i = 0; i < 3; i++) add(0, 0, o_if(0), "w2_if_wait");
        add(0, 0, o_err(), "w2_if_timeout"); add(0, 1, o_err(), "w2_err_sticky");
        add(1, 1, o_rst(), "w2_reset2");
        add(0, 0, o_if(0), "w2_if_w1"); add(0, 0, o_if(0), "w2_if_w2");
        add(0, 1, o_if(1), "w2_if_ok"); add(0, 1, o_id(), "w2_id");
        add(0, 1, o_ex(0, 3'd0, 0, 2'd0, 0), "w2_ex"); add(0, 1, o_wb(2'd0, 2'd0), "w2_wb");
        instr(6'h2b, 6'h00, 1'b0);
        add(0, 1, o_if(1), "w2_sw_if"); add(0, 1, o_id(), "w2_sw_id");
        add(0, 1, o_ex(1, 3'd0, 0, 2'd0, 0), "w2_sw_ex");
        for (int i = 0; i < 3; i++) add(0, 0, o_mem(0, 1, 0), "w2_mem_wait");
        add(0, 0, o_err(), "w2_mem_timeout");
        add(1, 0, o_rst(), "w2_reset3");

        cur_dut = 2;
        add(1, 0, o_rst(), "nw_reset");
        instr(6'h23, 6'h00, 1'b0);
        add(0, 0, o_if(1), "nw_lw_if"); add(0, 0, o_id(), "nw_lw_id");
        add(0, 0, o_ex(1, 3'd0, 0, 2'd0, 0), "nw_lw_ex");
        add(0, 0, o_mem(1, 0, 0), "nw_lw_mem"); add(0, 0, o_wb(2'd2, 2'd1), "nw_lw_wb");
        instr(6'h2b, 6'h00, 1'b0);
        add(0, 0, o_if(1), "nw_sw_if"); add(0, 0, o_id(), "nw_sw_id");
        add(0, 0, o_ex(1, 3'd0, 0, 2'd0, 0), "nw_sw_ex");
        add(0, 0, o_mem(0, 1, 1), "nw_sw_mem"); add(0, 0, o_if(1), "nw_next_if");
    endtask

    always @(negedge clk) begin
        if (sbq.size() != 0) begin
            sb_t e;
            e = sbq.pop_front();
            checks++;
            if (act[e.dut] !== e.exp) begin
                errors++;
                $display("FAIL %s: dut%0d outputs=%h expected=%h", e.name, e.dut, act[e.dut], e.exp);
            end
        end
    end

    initial begin
        build_table();
        for (int i = 0; i < tbl.size(); i++) begin
            sb_t s;
            @(posedge clk);
            #1;
            reset     = tbl[i].rst;
            opcode    = tbl[i].op;
            funct     = tbl[i].fn;
            zero      = tbl[i].z;
            mem_ready = tbl[i].rdy;
            s.dut  = tbl[i].dut;
            s.exp  = tbl[i].exp;
            s.name = tbl[i].name;
            sbq.push_back(s);
        end
        repeat (3) @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
